// File: rtl/mult_accumulator.sv
// mult_accumulator
//   Multiply-accumulate stage fed by the 32x32 signed tree multiplier.
//   Each accepted beat either accumulates, loads, subtracts or clears a
//   64-bit signed accumulator. A beat flagged in_last closes the group,
//   and the result is moved into a single registered output slot.
//
// Parameters
//   SATURATE  1 = clamp to signed 64-bit limits on overflow, 0 = wrap
// Ports
//   clk, rst          clock (rising edge), async active-high reset
//   in_valid/in_ready product beat handshake
//   in_prod [63:0]    signed product
//   in_op   [1:0]     00 ACC, 01 LOAD, 10 SUB, 11 CLEAR
//   in_last           beat closes the current group
//   out_valid/ready   result handshake
//   out_acc [63:0]    signed group result
//   out_ovf           sticky overflow seen in the group
//   out_count [15:0]  accepted beats in the group, saturating
module mult_accumulator #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_prod,
  input  logic [1:0]  in_op,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_acc,
  output logic        out_ovf,
  output logic [15:0] out_count
);

  localparam logic [1:0] OP_ACC   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [63:0] S64_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] S64_MIN = 64'h8000_0000_0000_0000;

  logic [63:0] acc;
  logic        ovf;
  logic [15:0] cnt;

  logic        fire;
  logic        fire_last;
  logic [64:0] sum;
  logic        sum_ovf;
  logic [63:0] nxt;
  logic        ovf_next;
  logic [15:0] cnt_next;

  // Output slot frees up in the same cycle the consumer takes it.
  assign in_ready  = ~out_valid | out_ready;
  assign fire      = in_valid & in_ready;
  assign fire_last = fire & in_last;

  // One sign-extended 65-bit adder serves ACC and SUB; the two top bits
  // disagree exactly when the 64-bit signed result is out of range.
  always_comb begin
    if (in_op == OP_SUB) sum = {acc[63], acc} - {in_prod[63], in_prod};
    else                 sum = {acc[63], acc} + {in_prod[63], in_prod};
  end
  assign sum_ovf = sum[64] ^ sum[63];

  always_comb begin
    nxt      = acc;
    ovf_next = ovf;
    unique case (in_op)
      OP_ACC, OP_SUB: begin
        if (sum_ovf) begin
          ovf_next = 1'b1;
          // bit 64 holds the true sign of the unclamped result
          if (SATURATE) nxt = sum[64] ? S64_MIN : S64_MAX;
          else          nxt = sum[63:0];
        end else begin
          nxt = sum[63:0];
        end
      end
      OP_LOAD:  nxt = in_prod;
      OP_CLEAR: begin
        nxt      = '0;
        ovf_next = 1'b0;
      end
      default: ;
    endcase
  end

  assign cnt_next = (&cnt) ? cnt : cnt + 16'd1;

  // Running group state; a last beat hands the group off and restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (fire) begin
      if (in_last) begin
        acc <= '0;
        ovf <= 1'b0;
        cnt <= '0;
      end else begin
        acc <= nxt;
        ovf <= ovf_next;
        cnt <= cnt_next;
      end
    end
  end

  // Output slot: a last-beat accept always (re)loads it, which covers the
  // drain-and-reload case; otherwise a consumer accept empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else if (fire_last) begin
      out_valid <= 1'b1;
      out_acc   <= nxt;
      out_ovf   <= ovf_next;
      out_count <= cnt_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_accumulator.sv
module tb_mult_accumulator;

  localparam longint S_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam longint S_MIN = 64'sh8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_prod;
  logic [1:0]  in_op;
  logic        in_last;
  logic        out_ready;

  // index 0: wrap instance, index 1: saturating instance
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [63:0] out_acc   [2];
  logic        out_ovf   [2];
  logic [15:0] out_count [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_accumulator #(.SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_prod(in_prod), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_acc(out_acc[0]),
    .out_ovf(out_ovf[0]), .out_count(out_count[0])
  );

  mult_accumulator #(.SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_prod(in_prod), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_acc(out_acc[1]),
    .out_ovf(out_ovf[1]), .out_count(out_count[1])
  );

  // reference model state
  longint m_acc  [2];
  bit     m_ovf  [2];
  longint m_oacc [2];
  bit     m_oovf [2];
  int     m_cnt;
  int     m_ocnt;
  bit     m_ov;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_acc[s] = 0; m_ovf[s] = 0; m_oacc[s] = 0; m_oovf[s] = 0;
    end
    m_cnt = 0; m_ocnt = 0; m_ov = 0;
  endtask

  // One beat evaluated with signed 64-bit arithmetic and sign-rule overflow.
  function automatic void calc(input bit sat, input longint a, input longint p,
                               input logic [1:0] op, input bit o,
                               output longint n, output bit on);
    longint w;
    bit     of;
    n = a; on = o; of = 0; w = 0;
    case (op)
      2'b00: begin w = a + p; of = ((a < 0) == (p < 0)) && ((w < 0) != (a < 0)); end
      2'b10: begin w = a - p; of = ((a < 0) != (p < 0)) && ((w < 0) != (a < 0)); end
      default: ;
    endcase
    case (op)
      2'b01: n = p;
      2'b11: begin n = 0; on = 0; end
      default: begin
        if (of) begin
          on = 1;
          n = !sat ? w : ((a < 0) ? S_MIN : S_MAX);
        end else begin
          n = w;
        end
      end
    endcase
  endfunction

  task automatic check_regs(input string tag);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("%s[%0d].valid", tag, s), 64'(out_valid[s]), 64'(m_ov));
      chk($sformatf("%s[%0d].acc", tag, s), out_acc[s], m_oacc[s]);
      chk($sformatf("%s[%0d].ovf", tag, s), 64'(out_ovf[s]), 64'(m_oovf[s]));
      chk($sformatf("%s[%0d].count", tag, s), 64'(out_count[s]), 64'(m_ocnt));
    end
  endtask

  // Called at a negedge with inputs already driven; runs one clock.
  task automatic tick(input string tag);
    bit     rdy, fire;
    longint n   [2];
    bit     on  [2];
    int     cn;
    #1;
    rdy = !m_ov || out_ready;
    for (int s = 0; s < 2; s++) chk($sformatf("%s[%0d].in_ready", tag, s), 64'(in_ready[s]), 64'(rdy));
    fire = in_valid && rdy;
    for (int s = 0; s < 2; s++) calc(s[0], m_acc[s], longint'(in_prod), in_op, m_ovf[s], n[s], on[s]);
    cn = (m_cnt == 65535) ? 65535 : m_cnt + 1;
    @(posedge clk);
    if (fire && in_last) begin
      for (int s = 0; s < 2; s++) begin
        m_oacc[s] = n[s]; m_oovf[s] = on[s]; m_acc[s] = 0; m_ovf[s] = 0;
      end
      m_ocnt = cn; m_cnt = 0; m_ov = 1;
    end else begin
      if (fire) begin
        for (int s = 0; s < 2; s++) begin m_acc[s] = n[s]; m_ovf[s] = on[s]; end
        m_cnt = cn;
      end
      if (out_ready) m_ov = 0;
    end
    @(negedge clk);
    check_regs(tag);
  endtask

  task automatic beat(input string tag, input logic [1:0] op, input longint p, input bit last);
    in_valid = 1'b1; in_op = op; in_prod = p; in_last = last;
    tick(tag);
  endtask

  task automatic idle(input string tag);
    in_valid = 1'b0; in_op = $urandom; in_prod = {$urandom, $urandom}; in_last = $urandom;
    tick(tag);
  endtask

  // Reset asserted mid-phase, outputs must clear before any clock edge.
  task automatic async_rst(input string tag);
    #2 rst = 1'b1;
    #1 model_reset();
    check_regs(tag);
    for (int s = 0; s < 2; s++) chk($sformatf("%s[%0d].in_ready", tag, s), 64'(in_ready[s]), 64'd1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] held [2];
    rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_op = '0; in_last = 1'b0; out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    check_regs("reset");
    for (int s = 0; s < 2; s++) chk("reset.in_ready", 64'(in_ready[s]), 64'd1);
    rst = 1'b0;

    // basic accumulation
    beat("basic", 2'b00, 3, 0);
    beat("basic", 2'b00, -5, 0);
    beat("basic", 2'b00, 10, 1);
    chk("basic.acc", out_acc[1], 64'd8);
    chk("basic.count", 64'(out_count[1]), 64'd3);
    idle("basic");

    // overflow, both modes
    beat("ovf", 2'b01, S_MAX, 0);
    beat("ovf", 2'b00, 1, 1);
    chk("ovf.sat_acc", out_acc[1], 64'h7FFF_FFFF_FFFF_FFFF);
    chk("ovf.wrap_acc", out_acc[0], 64'h8000_0000_0000_0000);
    chk("ovf.flag", 64'(out_ovf[0] & out_ovf[1]), 64'd1);
    beat("ovf2", 2'b01, 2, 1);
    chk("ovf2.acc", out_acc[0], 64'd2);
    chk("ovf2.flag", 64'(out_ovf[0] | out_ovf[1]), 64'd0);

    // backpressure: result pending, next last beat waits
    out_ready = 1'b0;
    beat("bp", 2'b01, 77, 1);
    for (int s = 0; s < 2; s++) held[s] = out_acc[s];
    for (int c = 0; c < 5; c++) begin
      beat("bp.hold", 2'b01, 55, 1);
      chk("bp.stable", out_acc[1], held[1]);
    end
    out_ready = 1'b1;
    beat("bp.release", 2'b01, 55, 1);
    chk("bp.reload", out_acc[1], 64'd55);
    idle("bp");

    // streaming single-beat groups
    for (int k = 1; k <= 8; k++) begin
      beat("stream", 2'b01, k, 1);
      chk("stream.acc", out_acc[0], 64'(k));
    end
    idle("stream");

    // clear mid-group
    beat("clr", 2'b00, 100, 0);
    beat("clr", 2'b11, 12345, 0);
    beat("clr", 2'b10, 4, 1);
    chk("clr.acc", out_acc[1], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("clr.count", 64'(out_count[1]), 64'd3);
    idle("clr");

    // async reset mid-group, then with a pending result
    beat("arst", 2'b00, 5, 0);
    async_rst("arst.mid");
    out_ready = 1'b0;
    beat("arst", 2'b00, 7, 1);
    async_rst("arst.full");
    out_ready = 1'b1;
    beat("arst.after", 2'b00, 6, 1);
    chk("arst.after.acc", out_acc[0], 64'd6);
    chk("arst.after.count", 64'(out_count[0]), 64'd1);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      longint p;
      case ($urandom_range(0, 3))
        0: p = longint'($signed(16'($urandom)));
        1: p = S_MAX - longint'($urandom_range(0, 3));
        2: p = S_MIN + longint'($urandom_range(0, 3));
        default: p = longint'({$urandom, $urandom});
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 4) != 0);
      in_op     = $urandom;
      in_prod   = p;
      in_last   = ($urandom_range(0, 3) == 0);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mult_accumulator.md
# mult_accumulator

Sequential multiply-accumulate stage that sits directly downstream of the 32x32 signed tree multiplier. It consumes the multiplier's 64-bit signed product through a valid/ready handshake. It accumulates, loads, subtracts or clears a 64-bit signed accumulator per beat, and emits one registered result per group, marked by `in_last`. The result carries a sticky overflow flag and a beat count. Overflow handling (saturate or wrap) is selected at elaboration.

## Interface
- `SATURATE`, default 1: 1 = clamp to signed 64-bit limits on overflow; 0 = two's-complement wrap.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: product beat valid.
- `in_ready` out 1: stage can accept a beat.
- `in_prod` in 64: signed product (multiplier `z`).
- `in_op` in 2: 00 ACC, 01 LOAD, 10 SUB, 11 CLEAR.
- `in_last` in 1: beat closes the current group.
- `out_valid` out 1: result register holds a group result.
- `out_ready` in 1: consumer accepts the result.
- `out_acc` out 64: signed group result.
- `out_ovf` out 1: sticky overflow for the emitted group.
- `out_count` out 16: accepted beats in the emitted group, saturating at 0xFFFF.

## Operation
- Accept condition: `in_valid & in_ready`. `in_ready = ~out_valid | out_ready` (combinational).
- Per accepted beat, next value `nxt` is computed from `acc`:
  - ACC: `acc + in_prod`
  - LOAD: `in_prod`
  - SUB: `acc - in_prod`
  - CLEAR: 0, with `in_prod` ignored and the group's `ovf` cleared.
- Arithmetic is done at 65 bits, sign-extended. Overflow is defined as bit 64 != bit 63 of the 65-bit result (ACC/SUB only).
- On overflow:
  - `SATURATE=1`: `nxt` = 0x7FFF_FFFF_FFFF_FFFF for positive overflow, 0x8000_0000_0000_0000 for negative overflow.
  - `SATURATE=0`: `nxt` = the low 64 bits.
  - Either mode sets the internal sticky `ovf`.
- Later beats in the group continue from the clamped or wrapped value.
- Every accepted beat, including CLEAR, increments the internal `cnt`, saturating at 0xFFFF.
- On an accepted beat with `in_last=0`: `acc <= nxt`, `ovf <= ovf_next`, `cnt <= cnt+1`.
- On an accepted beat with `in_last=1`:
  - `out_acc <= nxt`, `out_ovf <= ovf_next`, `out_count <= cnt+1`, `out_valid <= 1`.
  - Same edge: `acc <= 0`, `ovf <= 0`, `cnt <= 0`. The next beat starts a fresh group.
- Output drain: `out_valid & out_ready` with no new last-beat accept → `out_valid <= 0`.
  - A simultaneous drain and last-beat accept reloads the output register; `out_valid` stays 1.
- While `out_valid & ~out_ready`: `out_acc`, `out_ovf` and `out_count` are held stable, and `in_ready=0`.
- Two-state view of the output register: EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
  - EMPTY → FULL on a last-beat accept.
  - FULL → EMPTY on a drain with no last-beat accept.
  - FULL → FULL on a drain plus a last-beat accept.

## Timing
- Reset values (asynchronous, immediate on `rst` high): `acc`=0, `ovf`=0, `cnt`=0, `out_valid`=0, `out_acc`=0, `out_ovf`=0, `out_count`=0.
- `in_ready` is 1 during and after reset.
- Reset mid-group discards the partial accumulation. Reset with `out_valid=1` drops the pending result.
- Latency: `out_valid` rises on the clock edge that accepts the last beat, so the result is visible in the cycle after that beat's handshake.
- Throughput: one beat per cycle sustained while `out_ready=1`, including back-to-back single-beat groups.
- No combinational path from `in_prod` to `out_acc`. `out_ready` reaches `in_ready` combinationally; this is the only comb path.
- Inputs are sampled only on accepted beats. `in_op`/`in_prod`/`in_last` are don't-care when `in_valid=0`.

## Test plan
- **Basic accumulation:** reset, then ACC 3, ACC -5, ACC 10 with `in_last` on the third beat, `out_ready=1` → next cycle `out_valid=1`, `out_acc`=8, `out_ovf`=0, `out_count`=3.
- **Overflow:** LOAD 0x7FFF_FFFF_FFFF_FFFF, then ACC 1 with `in_last`.
  - `SATURATE=1` → `out_acc`=0x7FFF_FFFF_FFFF_FFFF, `out_ovf`=1.
  - `SATURATE=0` → `out_acc`=0x8000_0000_0000_0000, `out_ovf`=1.
  - A following single-beat group LOAD 2 with `in_last` → `out_acc`=2, `out_ovf`=0.
- **Backpressure:** result pending, `out_ready=0` for 5 cycles → `in_ready`=0 and outputs stable throughout. Raise `out_ready` with a last beat waiting → drain and new load occur on the same edge, and `out_valid` stays 1.
- **Streaming:** LOAD k with `in_last`, for k=1..8 on consecutive cycles, `out_ready=1` → eight results 1..8 on consecutive cycles, each with `out_count`=1.
- **CLEAR mid-group:** ACC 100, CLEAR, SUB 4 with `in_last` → `out_acc`=-4 (0xFFFF_FFFF_FFFF_FFFC), `out_count`=3, `out_ovf`=0.
- **Async reset:** assert `rst` between clock edges, once mid-group and once with `out_valid=1` → all outputs zero immediately. After release, ACC 6 with `in_last` → `out_acc`=6, `out_count`=1.
